// File: rtl/xalu_seq_if.sv
// Bundle of request, result and multiplier/divider side-channel signals for xalu_seq.
// slave is the sequencer's view; master is the execute/unit side.
interface xalu_seq_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mul_gpr_valid;
    logic [31:0] mul_gpr_data;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_res;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    modport slave (
        input  req_valid, req_op, req_a, req_b, kill,
        input  mul_res, div_done, div_quot, div_rem,
        output busy, hi, lo, mul_gpr_valid, mul_gpr_data,
        output mul_start, mul_signed, mul_a, mul_b,
        output div_start, div_signed, div_a, div_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, kill,
        output mul_res, div_done, div_quot, div_rem,
        input  busy, hi, lo, mul_gpr_valid, mul_gpr_data,
        input  mul_start, mul_signed, mul_a, mul_b,
        input  div_start, div_signed, div_a, div_b
    );
endinterface

// File: rtl/xalu_seq.sv
// Multiply/divide sequencer: dispatches one op at a time to an external pipelined
// multiplier or variable-latency divider and owns the architectural HI/LO registers.
module xalu_seq #(
    parameter int unsigned MUL_LAT = 3
) (
    input logic       Clk,
    input logic       Clr_n,
    xalu_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DRAIN} state_t;
    typedef enum logic [2:0] {
        OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MUL
    } op_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    op_t         op_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        gpr_valid_q;
    logic [31:0] gpr_data_q;

    op_t  req_op_d;
    logic accept_d;
    logic is_mul_d;
    logic is_div_d;

    always_comb begin
        req_op_d = op_t'(bus.req_op);
        accept_d = bus.req_valid && !bus.kill && (state_q == IDLE) && (req_op_d != OP_NOP);
        is_mul_d = req_op_d inside {OP_MULT, OP_MULTU, OP_MUL};
        is_div_d = req_op_d inside {OP_DIV, OP_DIVU};
    end

    assign bus.mul_start  = accept_d && is_mul_d;
    assign bus.mul_signed = (req_op_d == OP_MULT) || (req_op_d == OP_MUL);
    assign bus.mul_a      = bus.req_a;
    assign bus.mul_b      = bus.req_b;
    assign bus.div_start  = accept_d && is_div_d;
    assign bus.div_signed = (req_op_d == OP_DIV);
    assign bus.div_a      = bus.req_a;
    assign bus.div_b      = bus.req_b;

    assign bus.busy          = (state_q != IDLE);
    assign bus.hi            = hi_q;
    assign bus.lo            = lo_q;
    assign bus.mul_gpr_valid = gpr_valid_q;
    assign bus.mul_gpr_data  = gpr_data_q;

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= OP_NOP;
            hi_q        <= '0;
            lo_q        <= '0;
            gpr_valid_q <= 1'b0;
            gpr_data_q  <= '0;
        end else begin
            gpr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        op_q <= req_op_d;
                        if (req_op_d == OP_MTHI) begin
                            hi_q <= bus.req_a;
                        end else if (req_op_d == OP_MTLO) begin
                            lo_q <= bus.req_a;
                        end else if (is_mul_d) begin
                            state_q <= MUL_WAIT;
                            cnt_q   <= CNT_INIT;
                        end else if (is_div_d) begin
                            state_q <= DIV_WAIT;
                        end
                    end
                end
                MUL_WAIT: begin
                    // kill wins even in the completion cycle: nothing is committed
                    if (bus.kill) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        if (op_q == OP_MUL) begin
                            gpr_valid_q <= 1'b1;
                            gpr_data_q  <= bus.mul_res[31:0];
                        end else begin
                            hi_q <= bus.mul_res[63:32];
                            lo_q <= bus.mul_res[31:0];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DIV_WAIT: begin
                    if (bus.div_done) begin
                        state_q <= IDLE;
                        if (!bus.kill) begin
                            lo_q <= bus.div_quot;
                            hi_q <= bus.div_rem;
                        end
                    end else if (bus.kill) begin
                        // the divider cannot be aborted, so hold busy until it finishes
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.div_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/xalu_seq.md
Name: xalu_seq

Overview:
- Sequencer and owner of the architectural HI/LO registers for the multi-cycle multiply/divide resource in the execute stage.
- Accepts one op at a time from execute and dispatches it to an external fixed-latency pipelined multiplier or a variable-latency divider.
- Tracks completion, commits results to HI/LO or returns the MUL GPR result, and drives the busy stall.
- Handles exception kill, including draining a divider that cannot be aborted.

Parameters:
MUL_LAT, 3, cycles from mul_start to valid mul_res (legal range 1..15)

Ports:
Clk  in  1  clock, all state updates on rising edge
Clr_n  in  1  asynchronous active-low reset
req_valid  in  1  execute presents an op this cycle
req_op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MUL
req_a  in  32  rs operand (forwarded)
req_b  in  32  rt operand (forwarded)
kill  in  1  exception or flush: cancel any in-flight op
busy  out  1  resource occupied; execute must stall and hold its request
hi  out  32  architectural HI
lo  out  32  architectural LO
mul_gpr_valid  out  1  one-cycle pulse: MUL result available for GPR writeback
mul_gpr_data  out  32  MUL result, low 32 bits
mul_start  out  1  multiplier launch pulse
mul_signed  out  1  signed multiply
mul_a  out  32  multiplier operand A
mul_b  out  32  multiplier operand B
mul_res  in  64  multiplier product, valid MUL_LAT cycles after mul_start
div_start  out  1  divider launch pulse
div_signed  out  1  signed divide
div_a  out  32  dividend
div_b  out  32  divisor
div_done  in  1  one-cycle pulse: quotient and remainder valid
div_quot  in  32  quotient
div_rem  in  32  remainder

Behaviour:
- Reset (async, Clr_n low): state IDLE, cnt=0, pending-op register=0, hi=lo=0, mul_gpr_valid=0, mul_gpr_data=0.
- Reset mid-operation abandons the op. A div_done arriving after reset is ignored in IDLE.
- States: IDLE, MUL_WAIT, DIV_WAIT, DRAIN. busy = (state != IDLE), registered-state decode.
- accept = req_valid & !kill & state==IDLE & req_op!=0. Requests while busy are not accepted; the requester holds them.
- mul_start, div_start, mul_signed, div_signed, mul_a/b and div_a/b are combinational from accept, req_op and req_a/b.
  - mul_start = accept & op in {MULT, MULTU, MUL}.
  - div_start = accept & op in {DIV, DIVU}.
  - mul_signed is 1 for MULT and MUL; div_signed is 1 for DIV.
  - Operands pass through unchanged. Start pulses are never asserted outside accept.
- MTHI/MTLO: on the accept edge, hi<=req_a or lo<=req_a. State stays IDLE, zero stall.
- MULT/MULTU/MUL: on the accept edge, state<=MUL_WAIT, cnt<=MUL_LAT-1, and the op is latched.
  - In MUL_WAIT: cnt decrements each cycle. The completion cycle is cnt==0; mul_res is sampled in that cycle.
  - MULT/MULTU completion: hi<=mul_res[63:32], lo<=mul_res[31:0].
  - MUL completion: mul_gpr_valid<=1 and mul_gpr_data<=mul_res[31:0] (registered, visible the cycle after completion). HI/LO unchanged.
  - In all cases state<=IDLE on completion.
  - busy is high for exactly MUL_LAT cycles; a back-to-back request is accepted in the first cycle busy is low.
- DIV/DIVU: on the accept edge, state<=DIV_WAIT. On div_done: lo<=div_quot, hi<=div_rem, state<=IDLE. Divide-by-zero commits whatever the divider returns.
- mul_gpr_valid is 0 in every cycle except the single cycle following a MUL completion.
- kill:
  - In IDLE: no effect; a same-cycle request is dropped.
  - In MUL_WAIT, including the completion cycle: state<=IDLE, no HI/LO write, no mul_gpr_valid.
  - In DIV_WAIT with div_done=0: state<=DRAIN, busy stays high.
  - In DIV_WAIT with div_done=1: result discarded, state<=IDLE.
  - In DRAIN: no effect.
- DRAIN: wait for div_done, discard the result, then state<=IDLE. No new request is accepted until then.
- Only the state machine writes hi/lo; at most one write per cycle, so no write conflict exists.

Test Plan:
- Reset then MTHI a=0x12345678, next cycle MTLO a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0; busy never high.
- MULT a=0xFFFFFFFE, b=3 (MUL_LAT=3, model returns signed product) -> busy high 3 cycles, mul_start 1 cycle, mul_signed=1; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MUL a=7, b=6 -> mul_gpr_valid single pulse with data 0x2A, one cycle after completion; hi/lo unchanged.
- DIVU a=100, b=7, div_done after 10 cycles -> busy high 10 cycles, then lo=14, hi=2; back-to-back MULTU is accepted the next cycle.
- DIV issued, kill 2 cycles later, div_done 8 cycles later -> DRAIN, busy held until div_done, hi/lo unchanged, then IDLE; kill asserted in the same cycle as a MULT request -> mul_start=0.
- Clr_n pulsed low during MUL_WAIT -> state IDLE, hi=lo=0, busy=0 immediately (asynchronous), no mul_gpr_valid.
